// File: rtl/axi_fifo_flop_n.sv
// rtl/axi_fifo_flop_n.sv - AXI-Stream flop FIFO with registered outputs and optional packet gating
module axi_fifo_flop_n #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int PKT_MODE = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [CW-1:0]    occupied,
    output logic [CW-1:0]    space,
    output logic             pkt_ovf
);

    // Packet mode can hold DEPTH words with the output register still empty.
    localparam int BUF_N = (PKT_MODE != 0) ? DEPTH : DEPTH - 1;
    localparam int PW    = (BUF_N > 1) ? $clog2(BUF_N) : 1;

    // Sized to the pointer range so indexing is exact; entries past BUF_N are never addressed.
    logic [WIDTH:0] mem [2**PW];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;

    logic          acc;
    logic          rel;
    logic          out_free;
    logic          eligible;
    logic          load_buf;
    logic          load_byp;
    logic          wr_buf;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] occupied_next;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_N - 1)) ? '0 : p + 1'b1;
    endfunction

    assign acc           = i_tvalid & i_tready;
    assign rel           = o_tvalid & o_tready;
    assign out_free      = ~o_tvalid | o_tready;
    assign buf_count     = occupied - CW'(o_tvalid);
    assign occupied_next = occupied + CW'(acc) - CW'(rel);

    // Buffered words go first; the incoming word bypasses only into an empty buffer.
    assign load_buf = out_free & (buf_count != '0) & eligible;
    assign load_byp = out_free & (buf_count == '0) & acc & eligible;
    assign wr_buf   = acc & ~load_byp;

    generate
        if (PKT_MODE != 0) begin : g_pkt
            logic [CW-1:0] pkt_cnt;
            logic [CW-1:0] pkt_avail;
            logic [CW-1:0] pkt_cnt_next;
            logic          draining;
            logic          drain_eff;
            logic          ovf_r;
            logic          ovf_next;

            // A tlast accepted this cycle does not count until the next edge.
            assign pkt_avail    = pkt_cnt - CW'(rel & o_tlast);
            assign pkt_cnt_next = pkt_avail + CW'(acc & i_tlast);
            assign drain_eff    = rel ? ~o_tlast : draining;
            assign eligible     = (pkt_avail != '0) | drain_eff;
            assign ovf_next     = (occupied_next == CW'(DEPTH)) & (pkt_cnt_next == '0);

            always_ff @(posedge clk) begin
                if (reset | clear) begin
                    pkt_cnt  <= '0;
                    draining <= 1'b0;
                    ovf_r    <= 1'b0;
                end else begin
                    pkt_cnt  <= pkt_cnt_next;
                    draining <= drain_eff | ovf_next;
                    ovf_r    <= ovf_r | ovf_next;
                end
            end

            assign pkt_ovf = ovf_r;
        end else begin : g_nopkt
            assign eligible = 1'b1;
            assign pkt_ovf  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            o_tvalid <= 1'b0;
            i_tready <= 1'b1;
            occupied <= '0;
            space    <= CW'(DEPTH);
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            if (wr_buf) begin
                wptr <= next_ptr(wptr);
            end
            if (load_buf) begin
                rptr <= next_ptr(rptr);
            end
            if (load_buf | load_byp) begin
                o_tvalid <= 1'b1;
            end else if (rel) begin
                o_tvalid <= 1'b0;
            end
            occupied <= occupied_next;
            space    <= CW'(DEPTH) - occupied_next;
            i_tready <= (occupied_next < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_buf) begin
            mem[wptr] <= {i_tlast, i_tdata};
        end
        if (load_buf) begin
            {o_tlast, o_tdata} <= mem[rptr];
        end else if (load_byp) begin
            {o_tlast, o_tdata} <= {i_tlast, i_tdata};
        end
    end

endmodule

// File: tb/tb_axi_fifo_flop_n.sv
// tb/tb_axi_fifo_flop_n.sv - self-checking bench for axi_fifo_flop_n
module tb_axi_fifo_flop_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clear    [4];
    logic [31:0] i_tdata  [4];
    logic        i_tlast  [4];
    logic        i_tvalid [4];
    logic        i_tready [4];
    logic [31:0] o_tdata  [4];
    logic        o_tlast  [4];
    logic        o_tvalid [4];
    logic        o_tready [4];
    logic        pkt_ovf  [4];
    logic [2:0]  occ_a, sp_a, occ_c, sp_c, occ_p, sp_p;
    logic [1:0]  occ_b, sp_b;

    axi_fifo_flop_n #(.WIDTH(32), .DEPTH(4), .PKT_MODE(0)) u_a (
        .clk(clk), .reset(reset), .clear(clear[0]),
        .i_tdata(i_tdata[0]), .i_tlast(i_tlast[0]), .i_tvalid(i_tvalid[0]), .i_tready(i_tready[0]),
        .o_tdata(o_tdata[0]), .o_tlast(o_tlast[0]), .o_tvalid(o_tvalid[0]), .o_tready(o_tready[0]),
        .occupied(occ_a), .space(sp_a), .pkt_ovf(pkt_ovf[0]));

    axi_fifo_flop_n #(.WIDTH(32), .DEPTH(2), .PKT_MODE(0)) u_b (
        .clk(clk), .reset(reset), .clear(clear[1]),
        .i_tdata(i_tdata[1]), .i_tlast(i_tlast[1]), .i_tvalid(i_tvalid[1]), .i_tready(i_tready[1]),
        .o_tdata(o_tdata[1]), .o_tlast(o_tlast[1]), .o_tvalid(o_tvalid[1]), .o_tready(o_tready[1]),
        .occupied(occ_b), .space(sp_b), .pkt_ovf(pkt_ovf[1]));

    axi_fifo_flop_n #(.WIDTH(32), .DEPTH(7), .PKT_MODE(0)) u_c (
        .clk(clk), .reset(reset), .clear(clear[2]),
        .i_tdata(i_tdata[2]), .i_tlast(i_tlast[2]), .i_tvalid(i_tvalid[2]), .i_tready(i_tready[2]),
        .o_tdata(o_tdata[2]), .o_tlast(o_tlast[2]), .o_tvalid(o_tvalid[2]), .o_tready(o_tready[2]),
        .occupied(occ_c), .space(sp_c), .pkt_ovf(pkt_ovf[2]));

    axi_fifo_flop_n #(.WIDTH(32), .DEPTH(4), .PKT_MODE(1)) u_p (
        .clk(clk), .reset(reset), .clear(clear[3]),
        .i_tdata(i_tdata[3]), .i_tlast(i_tlast[3]), .i_tvalid(i_tvalid[3]), .i_tready(i_tready[3]),
        .o_tdata(o_tdata[3]), .o_tlast(o_tlast[3]), .o_tvalid(o_tvalid[3]), .o_tready(o_tready[3]),
        .occupied(occ_p), .space(sp_p), .pkt_ovf(pkt_ovf[3]));

    int checks   = 0;
    int failures = 0;
    logic [32:0] mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int depth_of(input int k);
        case (k)
            1:       return 2;
            2:       return 7;
            default: return 4;
        endcase
    endfunction

    function automatic int occ_of(input int k);
        case (k)
            0:       return int'(occ_a);
            1:       return int'(occ_b);
            2:       return int'(occ_c);
            default: return int'(occ_p);
        endcase
    endfunction

    function automatic int sp_of(input int k);
        case (k)
            0:       return int'(sp_a);
            1:       return int'(sp_b);
            2:       return int'(sp_c);
            default: return int'(sp_p);
        endcase
    endfunction

    task automatic drive(input int k, input logic v, input logic [31:0] d, input logic l, input logic r);
        i_tvalid[k] = v;
        i_tdata[k]  = d;
        i_tlast[k]  = l;
        o_tready[k] = r;
    endtask

    // One cycle of a plain FIFO: handshakes decided from the queue model, not the DUT.
    task automatic step(input int k, input logic v, input logic [31:0] d, input logic l, input logic r);
        logic acc;
        logic rel;
        drive(k, v, d, l, r);
        acc = v && (mq.size() < depth_of(k));
        rel = r && (mq.size() > 0);
        if (rel) void'(mq.pop_front());
        if (acc) mq.push_back({l, d});
        @(negedge clk);
    endtask

    task automatic check_state(input int k, input string tag);
        int n;
        int dp;
        n  = mq.size();
        dp = depth_of(k);
        chk({tag, ".occupied"}, occ_of(k), n);
        chk({tag, ".space"}, sp_of(k), dp - n);
        chk({tag, ".i_tready"}, i_tready[k], n < dp);
        chk({tag, ".o_tvalid"}, o_tvalid[k], n > 0);
        if (n > 0) chk({tag, ".o_word"}, {o_tlast[k], o_tdata[k]}, mq[0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            clear[k] = 1'b0;
            drive(k, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        mq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int idx;
        int got;
        logic v;
        logic acc;

        do_reset();
        for (int k = 0; k < 4; k++) begin
            check_state(k, "reset");
            chk("reset.pkt_ovf", pkt_ovf[k], 1'b0);
        end

        // back-to-back writes with the sink always ready
        step(0, 1'b1, 32'h1, 1'b0, 1'b1);
        chk("t1.word1", o_tdata[0], 32'h1);
        check_state(0, "t1a");
        step(0, 1'b1, 32'h2, 1'b0, 1'b1);
        chk("t1.word2", o_tdata[0], 32'h2);
        step(0, 1'b1, 32'h3, 1'b0, 1'b1);
        chk("t1.word3", o_tdata[0], 32'h3);
        step(0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_state(0, "t1empty");

        // fill against a stalled sink, then drain
        n = 0;
        for (int i = 0; i < 8 && i_tready[0]; i++) begin
            step(0, 1'b1, 32'h10 + n, 1'b0, 1'b0);
            n++;
        end
        chk("t2.accepted", n, 4);
        check_state(0, "t2full");
        chk("t2.word0", o_tdata[0], 32'h10);
        step(0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2.ready_back", i_tready[0], 1'b1);
        for (int j = 1; j < 4; j++) begin
            chk("t2.order", o_tdata[0], 32'h10 + j);
            step(0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        check_state(0, "t2empty");

        // clear with three words held
        for (int i = 0; i < 3; i++) step(0, 1'b1, 32'h21 + i, 1'b0, 1'b0);
        check_state(0, "t3pre");
        clear[0] = 1'b1;
        drive(0, 1'b1, 32'h24, 1'b0, 1'b0);
        @(negedge clk);
        clear[0] = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
        mq.delete();
        chk("t3.o_tvalid", o_tvalid[0], 1'b0);
        chk("t3.occupied", occ_a, 3'd0);
        chk("t3.i_tready", i_tready[0], 1'b1);
        chk("t3.space", sp_a, 3'd4);

        // randomized traffic on DEPTH=2 and DEPTH=7
        for (int k = 1; k <= 2; k++) begin
            do_reset();
            for (int c = 0; c < 4000; c++) begin
                step(k, $urandom_range(0, 9) < 6, $urandom, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 6);
                check_state(k, "rnd");
            end
            for (int c = 0; c < 10; c++) step(k, 1'b0, 32'h0, 1'b0, 1'b1);
            check_state(k, "rnd_drain");
            chk("rnd.empty", occ_of(k), 0);
        end

        // packet mode: output held until the tlast has been stored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(3, 1'b1, 32'hA0 + i, i == 2, 1'b1);
            @(negedge clk);
            chk("p1.hold", o_tvalid[3], 1'b0);
        end
        chk("p1.occupied", occ_p, 3'd3);
        drive(3, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            chk("p1.o_tvalid", o_tvalid[3], 1'b1);
            chk("p1.o_tdata", o_tdata[3], 32'hA0 + j);
            chk("p1.o_tlast", o_tlast[3], j == 2);
            @(negedge clk);
        end
        chk("p1.done", o_tvalid[3], 1'b0);
        chk("p1.occ_end", occ_p, 3'd0);

        // packet mode overflow: 6-word packet into DEPTH=4 with a stalled sink
        do_reset();
        idx = 0;
        for (int i = 0; i < 10 && i_tready[3]; i++) begin
            drive(3, 1'b1, 32'hB0 + idx, idx == 5, 1'b0);
            @(negedge clk);
            idx++;
        end
        chk("p2.accepted", idx, 4);
        chk("p2.pkt_ovf", pkt_ovf[3], 1'b1);
        chk("p2.occupied", occ_p, 3'd4);
        chk("p2.i_tready", i_tready[3], 1'b0);
        drive(3, 1'b1, 32'hB0 + idx, 1'b0, 1'b0);
        @(negedge clk);
        chk("p2.drain_start", o_tvalid[3], 1'b1);
        chk("p2.first", o_tdata[3], 32'hB0);
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            v = (idx < 6);
            drive(3, v, 32'hB0 + idx, idx == 5, 1'b1);
            acc = v && i_tready[3];
            if (o_tvalid[3]) begin
                chk("p2.o_tdata", o_tdata[3], 32'hB0 + got);
                chk("p2.o_tlast", o_tlast[3], got == 5);
                got++;
            end
            @(negedge clk);
            if (acc) idx++;
        end
        chk("p2.released", got, 6);
        chk("p2.sent", idx, 6);
        drive(3, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("p2.empty", o_tvalid[3], 1'b0);
        chk("p2.sticky", pkt_ovf[3], 1'b1);
        do_reset();
        chk("p2.ovf_reset", pkt_ovf[3], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
